// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux
//   Four-master round-robin bus arbiter with a registered owner and a
//   combinational master-to-slave request multiplexer. Feeds the bus address
//   decoder with the owning master's address, strobe, direction and data.
//
// Parameters
//   ADDR_W    word-address width
//   DATA_W    write-data width
//   MAX_HOLD  max consecutive owned cycles while another master requests
//             (0 disables forced rotation)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   mN_req_/mN_addr/mN_as_/
//   mN_rw/mN_wr_data           per-master request, address, strobe (low),
//                              direction (1 = read) and write data
//   mN_grnt_                   per-master grant, active low, exactly one low
//   s_addr/s_as_/s_rw/
//   s_wr_data                  owning master's signals, to the decoder
module bus_arbiter_mux #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic              m1_req_,
  input  logic              m2_req_,
  input  logic              m3_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m0_as_,
  input  logic              m1_as_,
  input  logic              m2_as_,
  input  logic              m3_as_,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic              m2_rw,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  output logic              m2_grnt_,
  output logic              m3_grnt_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data
);

  localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    OWN0 = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    OWN3 = 2'd3
  } owner_t;

  owner_t             r_owner;
  owner_t             w_owner_nxt;
  owner_t             w_cand;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [3:0]         w_req;
  logic [3:0]         w_others_req;
  logic               w_others;
  logic               w_force;
  logic               w_found;

  // Requests as active-high vector; the owner's own bit is masked out to
  // tell whether anybody else is waiting.
  assign w_req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_others_req = w_req & ~(4'b0001 << r_owner);
  assign w_others     = |w_others_req;

  // Output mux: combinational copy of the owner's signals.
  always_comb begin
    s_addr    = m0_addr;
    s_as_     = m0_as_;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    case (r_owner)
      OWN0: begin
        s_addr = m0_addr; s_as_ = m0_as_; s_rw = m0_rw; s_wr_data = m0_wr_data;
      end
      OWN1: begin
        s_addr = m1_addr; s_as_ = m1_as_; s_rw = m1_rw; s_wr_data = m1_wr_data;
      end
      OWN2: begin
        s_addr = m2_addr; s_as_ = m2_as_; s_rw = m2_rw; s_wr_data = m2_wr_data;
      end
      OWN3: begin
        s_addr = m3_addr; s_as_ = m3_as_; s_rw = m3_rw; s_wr_data = m3_wr_data;
      end
      default: ;
    endcase
  end

  // Forced rotation only on an idle cycle (owner strobe high), so a transfer
  // in progress is never cut.
  assign w_force = (MAX_HOLD != 0) && (r_hold == HOLD_MAX) && w_others && s_as_;

  // Next owner: keep unless released or forced; otherwise first requester
  // in round-robin order after the current owner, else stay parked.
  always_comb begin
    w_owner_nxt = r_owner;
    w_found     = 1'b0;
    w_cand      = r_owner;
    if (!w_req[r_owner] || w_force) begin
      for (int unsigned i = 1; i < 4; i++) begin
        w_cand = owner_t'(r_owner + 2'(i));
        if (!w_found && w_req[w_cand]) begin
          w_owner_nxt = w_cand;
          w_found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hold_nxt = r_hold;
    if ((w_owner_nxt != r_owner) || !w_others) begin
      w_hold_nxt = '0;
    end else if (r_hold < HOLD_MAX) begin
      w_hold_nxt = r_hold + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN0;
      r_hold  <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Grants decode straight from the owner register: one low at all times,
  // hand-over with neither overlap nor gap.
  assign m0_grnt_ = (r_owner != OWN0);
  assign m1_grnt_ = (r_owner != OWN1);
  assign m2_grnt_ = (r_owner != OWN2);
  assign m3_grnt_ = (r_owner != OWN3);

endmodule

// File: tb/tb_bus_arbiter_mux.sv
module tb_bus_arbiter_mux;

  localparam int unsigned AW   = 30;
  localparam int unsigned DW   = 32;
  localparam int          MAXH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_n = 4'hF;
  logic [3:0]    as_n  = 4'hF;
  logic [3:0]    rw    = 4'h0;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wd   [4];

  logic [3:0]    gnt_n;
  logic [AW-1:0] s_addr;
  logic          s_as_;
  logic          s_rw;
  logic [DW-1:0] s_wr_data;

  always #5 clk = ~clk;

  bus_arbiter_mux #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_addr(addr[0]), .m1_addr(addr[1]), .m2_addr(addr[2]), .m3_addr(addr[3]),
    .m0_as_(as_n[0]), .m1_as_(as_n[1]), .m2_as_(as_n[2]), .m3_as_(as_n[3]),
    .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
    .m0_wr_data(wd[0]), .m1_wr_data(wd[1]), .m2_wr_data(wd[2]), .m3_wr_data(wd[3]),
    .m0_grnt_(gnt_n[0]), .m1_grnt_(gnt_n[1]), .m2_grnt_(gnt_n[2]), .m3_grnt_(gnt_n[3]),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data)
  );

  typedef struct {
    logic [3:0]    gnt_n;
    logic [AW-1:0] addr;
    logic          as_;
    logic          rw;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: owner index and consecutive-hold count.
  int   m_owner = 0;
  int   m_hold  = 0;
  bit   m_valid = 0;

  function automatic void model_step(input logic [3:0] rq, input logic [3:0] asn, input logic rst);
    int  nxt;
    bit  others;
    bit  force_rot;
    if (rst) begin
      m_owner = 0;
      m_hold  = 0;
      m_valid = 1;
      return;
    end
    others = 0;
    for (int k = 0; k < 4; k++)
      if (k != m_owner && rq[k]) others = 1;
    force_rot = (MAXH != 0) && (m_hold == MAXH) && others && asn[m_owner];
    nxt = m_owner;
    if (!rq[m_owner] || force_rot) begin
      for (int k = 1; k < 4; k++) begin
        if (rq[(m_owner + k) % 4]) begin
          nxt = (m_owner + k) % 4;
          break;
        end
      end
    end
    if (nxt != m_owner || !others) m_hold = 0;
    else if (m_hold < MAXH) m_hold = m_hold + 1;
    m_owner = nxt;
  endfunction

  // Drive one cycle of stimulus (rq is active-high request), predict the
  // combinational outputs for this cycle, then advance the model across the
  // coming edge.
  task automatic apply(input logic [3:0] rq, input logic [3:0] asn, input logic rst,
                       input bit fix0, input logic [AW-1:0] a0);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req_n = ~rq;
    as_n  = asn;
    rw    = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      addr[k] = AW'($urandom);
      wd[k]   = $urandom;
    end
    if (fix0) addr[0] = a0;
    #1;
    if (m_valid) begin
      e.gnt_n = 4'hF & ~(4'b0001 << m_owner);
      e.addr  = addr[m_owner];
      e.as_   = as_n[m_owner];
      e.rw    = rw[m_owner];
      e.wd    = wd[m_owner];
      exp_q.push_back(e);
    end
    model_step(rq, asn, rst);
  endtask

  task automatic cyc(input logic [3:0] rq, input logic [3:0] asn, input int n);
    for (int i = 0; i < n; i++) apply(rq, asn, 1'b0, 1'b0, '0);
  endtask

  // Monitor: outputs are valid every cycle; compare whatever was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (gnt_n !== e.gnt_n) begin
          n_err++;
          $display("FAIL grant: got %b expected %b at %0t", gnt_n, e.gnt_n, $time);
        end
        n_vec++;
        if ($countones(~gnt_n) != 1) begin
          n_err++;
          $display("FAIL onehot_low: got %b expected exactly one low at %0t", gnt_n, $time);
        end
        n_vec++;
        if ({s_addr, s_as_, s_rw, s_wr_data} !== {e.addr, e.as_, e.rw, e.wd}) begin
          n_err++;
          $display("FAIL mux: got addr=%h as_=%b rw=%b wd=%h expected addr=%h as_=%b rw=%b wd=%h at %0t",
                   s_addr, s_as_, s_rw, s_wr_data, e.addr, e.as_, e.rw, e.wd, $time);
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] asn;
    // Reset, then test 1: park on m0, fixed address passes straight through.
    apply(4'b0000, 4'hF, 1'b1, 1'b0, '0);
    apply(4'b0000, 4'hF, 1'b1, 1'b0, '0);
    apply(4'b0001, 4'b1110, 1'b0, 1'b1, 30'h1000_0004);
    apply(4'b0001, 4'b1110, 1'b0, 1'b1, 30'h1000_0004);
    // Test 2: m0 releases, m2 takes over.
    cyc(4'b0100, 4'b1011, 3);
    // Test 3: move to m1, then m1 releases with m0/m2/m3 waiting.
    cyc(4'b0010, 4'b1101, 3);
    cyc(4'b1101, 4'hF, 2);
    cyc(4'b1001, 4'hF, 2);
    cyc(4'b0001, 4'hF, 2);
    // Test 4: m0 holds with an active transfer while m1 waits, then idles.
    apply(4'b0000, 4'hF, 1'b1, 1'b0, '0);
    cyc(4'b0011, 4'b1110, 6);
    cyc(4'b0011, 4'b1111, 3);
    // Test 5: no requests at all.
    cyc(4'b0000, 4'hF, 4);
    // Test 6: m3 owns mid-transfer, reset pulls the bus back to m0.
    cyc(4'b1000, 4'b0111, 3);
    apply(4'b1000, 4'b0111, 1'b1, 1'b0, '0);
    cyc(4'b1000, 4'b0111, 2);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rq  = 4'($urandom) & 4'($urandom);
      asn = 4'($urandom) | 4'($urandom_range(0, 1) ? 4'h0 : 4'hF);
      apply(rq, asn, ($urandom_range(0, 63) == 0), 1'b0, '0);
    end
    @(negedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
